// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the RVX10 five-stage pipe: forwarding, load-use and
// multi-cycle stalls with a watchdog. Define HAZARD_PERF_EN for stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       McStartE,
    input  logic       McDoneE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       McErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MC_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_err_q, mc_err_d;
    logic             busy, lw_stall, timeout;

    logic [1:0][4:0] rs_e;
    logic [1:0][1:0] fwd;

    assign rs_e = {Rs2E, Rs1E};

    // MEM wins over WB: it holds the younger write to the same register.
    always_comb begin
        fwd = '0;
        for (int i = 0; i < 2; i++) begin
            if (RegWriteM && RdM != 5'd0 && RdM == rs_e[i])
                fwd[i] = 2'b10;
            else if (RegWriteW && RdW != 5'd0 && RdW == rs_e[i])
                fwd[i] = 2'b01;
        end
    end

    assign lw_stall = ResultSrcE0 && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE);
    assign timeout  = (state_q == BUSY) && (cnt_q == TIMEOUT);
    assign busy     = ((state_q == RUN) && McStartE && !McDoneE) ||
                      ((state_q == BUSY) && !McDoneE && !timeout);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                cnt_d = '0;
                if (McStartE && !McDoneE) state_d = BUSY;
            end
            default: begin
                if (McDoneE || timeout) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        // Registered pulse lands in the cycle the counter sits at the limit.
        mc_err_d = (state_d == BUSY) && (cnt_d == TIMEOUT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            mc_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mc_err_q <= mc_err_d;
        end
    end

    // Busy dominates the load-use and branch terms.
    assign StallF    = reset_n && (lw_stall || busy);
    assign StallD    = StallF;
    assign StallE    = reset_n && busy;
    assign FlushM    = StallE;
    assign FlushD    = reset_n && PCSrcE && !busy;
    assign FlushE    = reset_n && (lw_stall || PCSrcE) && !busy;
    assign ForwardAE = reset_n ? fwd[0] : 2'b00;
    assign ForwardBE = reset_n ? fwd[1] : 2'b00;
    assign McErr     = mc_err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + 32'(StallF);
        flush_count_d  = flush_count_q + 32'(FlushD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle reference model plus literal spot checks.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, PCSrcE, McStartE, McDoneE, RegWriteM, RegWriteW;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McErr;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCycles, FlushCount;
    int unsigned m_stalls = 0, m_flushes = 0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pipe_hazard_ctrl #(.MC_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .McStartE(McStartE), .McDoneE(McDoneE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .McErr(McErr)
`ifdef HAZARD_PERF_EN
        , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: an op "in flight" and its age in cycles since it entered EX.
    bit in_op = 1'b0;
    int age   = 0;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM,ForwardAE,ForwardBE,McErr}
    function automatic logic [10:0] expect_out();
        logic lw, bz, err;
        if (!reset_n) return '0;
        lw = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        if (!in_op) begin
            err = 1'b0;
            bz  = McStartE && !McDoneE;
        end else begin
            err = (age == TO + 1);
            bz  = !McDoneE && !err;
        end
        return {lw | bz, lw | bz, bz, PCSrcE & ~bz, (lw | PCSrcE) & ~bz, bz,
                fwd_sel(Rs1E), fwd_sel(Rs2E), err};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_op <= 1'b0;
            age   <= 0;
`ifdef HAZARD_PERF_EN
            m_stalls  <= 0;
            m_flushes <= 0;
`endif
        end else begin
`ifdef HAZARD_PERF_EN
            m_stalls  <= m_stalls + 32'(expect_out() >> 10 & 11'd1);
            m_flushes <= m_flushes + 32'(expect_out() >> 7 & 11'd1);
`endif
            if (!in_op) begin
                if (McStartE && !McDoneE) begin
                    in_op <= 1'b1;
                    age   <= 1;
                end
            end else if (McDoneE || age == TO + 1) begin
                in_op <= 1'b0;
                age   <= 0;
            end else begin
                age <= age + 1;
            end
        end
    end

    wire [10:0] dut_v = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                         ForwardAE, ForwardBE, McErr};

    always @(negedge clk) begin
        logic [10:0] e;
        cyc = cyc + 1;
        e = expect_out();
        total = total + 1;
        if (dut_v !== e) begin
            bad = bad + 1;
            $display("FAIL model cyc=%0d got=%b want=%b", cyc, dut_v, e);
        end
`ifdef HAZARD_PERF_EN
        total = total + 1;
        if (StallCycles !== m_stalls || FlushCount !== m_flushes) begin
            bad = bad + 1;
            $display("FAIL perf cyc=%0d got=%0d/%0d want=%0d/%0d", cyc,
                     StallCycles, FlushCount, m_stalls, m_flushes);
        end
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {ResultSrcE0, PCSrcE, McStartE, McDoneE, RegWriteM, RegWriteW} = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    // Op enters EX now, done arrives k cycles later; stall exactly k cycles.
    task automatic mc_op(input int k);
        McStartE = 1'b1;
        for (int i = 0; i <= k + 1; i++) begin
            McDoneE = (i == k);
            if (i > k) McStartE = 1'b0;
            mid();
            chk($sformatf("mc_stallF_%0d", i), 32'(StallF), 32'(i < k));
            chk($sformatf("mc_flushM_%0d", i), 32'(FlushM), 32'(i < k));
            nxt();
        end
        McDoneE = 1'b0;
    endtask

    initial begin
        clr();
        repeat (2) nxt();
        chk("rst_stall", 32'({StallF, StallE, FlushM}), 32'd0);
        chk("rst_mcerr", 32'(McErr), 32'd0);
        reset_n = 1'b1;
        nxt();

        // Forwarding priority and x0 suppression
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 3;
        mid(); chk("fwdA_mem", 32'(ForwardAE), 32'd2); chk("fwdB_none", 32'(ForwardBE), 32'd0);
        nxt(); RegWriteM = 0; Rs2E = 5;
        mid(); chk("fwdA_wb", 32'(ForwardAE), 32'd1); chk("fwdB_wb", 32'(ForwardBE), 32'd1);
        nxt(); RegWriteM = 1; RdM = 0; RdW = 0;
        mid(); chk("fwdA_x0", 32'(ForwardAE), 32'd0);
        nxt(); clr();

        // Load-use, then RdE = x0
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        mid(); chk("lu_stall", 32'({StallF, StallD, FlushE}), 32'b111);
        chk("lu_flushD", 32'(FlushD), 32'd0);
        nxt(); clr();
        mid(); chk("lu_release", 32'(StallF), 32'd0);
        nxt(); ResultSrcE0 = 1; RdE = 0; Rs2D = 0;
        mid(); chk("lu_x0", 32'({StallF, FlushE}), 32'd0);
        nxt(); clr();

        // Taken branch
        PCSrcE = 1;
        mid(); chk("br_flush", 32'({FlushD, FlushE, StallF}), 32'b110);
        nxt(); clr();

        // Multi-cycle op, three stall cycles
        mc_op(3);
        mid(); chk("mc_run_after", 32'(StallE), 32'd0);
        nxt();

        // Single-cycle completion stays in RUN
        McStartE = 1; McDoneE = 1;
        mid(); chk("mc_single", 32'(StallE), 32'd0);
        nxt(); clr();
        mid(); chk("mc_single_run", 32'(StallE), 32'd0);
        nxt();

        // Busy dominates a branch and a load-use seen during BUSY
        McStartE = 1;
        nxt(); PCSrcE = 1; ResultSrcE0 = 1; RdE = 9; Rs1D = 9;
        mid(); chk("dom", 32'({StallF, StallE, FlushD, FlushE, FlushM}), 32'b11001);
        nxt(); McDoneE = 1; PCSrcE = 0; ResultSrcE0 = 0;
        nxt(); clr();

        // Watchdog: no done ever; McErr at N+TO+1 with stalls released, RUN after
        McStartE = 1;
        for (int i = 0; i <= TO + 2; i++) begin
            if (i == TO + 2) McStartE = 0;
            mid();
            chk($sformatf("to_stallE_%0d", i), 32'(StallE), 32'(i <= TO));
            chk($sformatf("to_mcerr_%0d", i), 32'(McErr), 32'(i == TO + 1));
            nxt();
        end
        clr();

        // Reset asynchronously during BUSY
        McStartE = 1;
        nxt(); nxt();
        mid(); chk("pre_rst_busy", 32'(StallE), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_async", 32'(dut_v), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("rst_perf", StallCycles | FlushCount, 32'd0);
`endif
        McStartE = 0;
        nxt();
        reset_n = 1'b1;
        nxt();
        mc_op(3);
        mid(); chk("post_rst_run", 32'({StallE, McErr}), 32'd0);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the RVX10 five-stage core. It is the control end of the pipeline-register interface: it produces the stall, flush and clear signals consumed by the IF/ID, ID/EX and EX/MEM registers, and the forwarding selects for the EX operand muxes. It also sequences multi-cycle RVX10 execute operations by holding the front of the pipe until the EX unit reports done, with a watchdog timeout.

## Interface
Parameters:
- MC_TIMEOUT, 64: maximum BUSY cycles before a forced release; legal range 2..255.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > MC_TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in ID.
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers of the instruction in EX.
- ResultSrcE0  in  1  the instruction in EX is a load.
- PCSrcE  in  1  a branch or jump is taken in EX.
- McStartE  in  1  the instruction in EX is a multi-cycle RVX10 op (level; valid in the op's first EX cycle).
- McDoneE  in  1  the multi-cycle unit's result is valid this cycle.
- RdM, RdW  in  5 each  destination registers in MEM and WB.
- RegWriteM, RegWriteW  in  1 each  register write enables in MEM and WB.
- StallF, StallD, StallE  out  1 each  hold the PC, IF/ID and ID/EX registers.
- FlushD, FlushE, FlushM  out  1 each  synchronous clear of IF/ID, ID/EX and EX/MEM.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- McErr  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Forwarding is combinational, with A and B handled identically. ForwardAE is 10 if RegWriteM, RdM != 0 and RdM == Rs1E. Otherwise it is 01 if RegWriteW, RdW != 0 and RdW == Rs1E. Otherwise it is 00. MEM has priority over WB.
- Load-use: lwStall = ResultSrcE0 & RdE != 0 & (Rs1D == RdE | Rs2D == RdE).
- Busy condition: busy = (state == RUN & McStartE & !McDoneE) | (state == BUSY & !McDoneE & cnt != MC_TIMEOUT).
- FSM has two states, RUN and BUSY.
  - RUN to BUSY when McStartE & !McDoneE.
  - BUSY to RUN when McDoneE, or when cnt == MC_TIMEOUT.
  - BUSY with neither condition stays in BUSY.
- Watchdog counter cnt:
  - Cleared to 0 in RUN.
  - Increments by 1 each BUSY cycle; never wraps.
  - When cnt == MC_TIMEOUT in BUSY: McErr = 1 for that single cycle, the stalls drop, and the FSM returns to RUN.
- Output equations:
  - StallF = StallD = lwStall | busy.
  - StallE = busy.
  - FlushM = busy, so bubbles enter MEM while EX holds.
  - FlushD = PCSrcE & !busy.
  - FlushE = (lwStall | PCSrcE) & !busy.
- A multi-cycle op is never a load or a branch, so busy, lwStall and PCSrcE are never set together. If they are, busy dominates.
- The multi-cycle unit latches its operands in its first EX cycle. Forward selects may change while BUSY as MEM and WB drain.
- McDoneE in the same cycle as McStartE in RUN is a single-cycle completion: no stall, and the FSM stays in RUN.

## Timing
- Reset (reset_n low, asynchronous):
  - state = RUN, cnt = 0, McErr = 0.
  - While reset_n is low, every stall, flush and forward output is forced to 0. Performance counters are also 0.
- Release: the first rising edge after reset_n goes high is normal operation.
- Stalls, flushes and forwards have zero latency: they are combinational from the current-cycle inputs and state.
- A multi-cycle op entering EX in cycle N stalls from cycle N. If McDoneE arrives in cycle N+k, the stalls drop in N+k, and the op advances to MEM on the edge ending N+k. The total stall is k cycles.
- Timeout: the op starts in cycle N, the counter reaches MC_TIMEOUT at cycle N+MC_TIMEOUT+1, and McErr pulses in that cycle.
- If reset_n is asserted during BUSY, the FSM returns to RUN immediately and no McErr is produced.

## Configuration
- HAZARD_PERF_EN defined adds two outputs:
  - StallCycles (32 bits): increments every cycle StallF is 1.
  - FlushCount (32 bits): increments every cycle FlushD is 1.
  - Both wrap at 2^32 and reset to 0.
- HAZARD_PERF_EN undefined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan
- Forwarding: RdM = 5 with RegWriteM = 1 and RdW = 5 with RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10. Drop RegWriteM -> ForwardAE = 01. Set RdM = RdW = 0 -> ForwardAE = 00.
- Load-use: ResultSrcE0 = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for exactly one cycle, with FlushD = 0. The same stimulus with RdE = 0 -> no stall.
- Branch: PCSrcE = 1 -> FlushD = FlushE = 1, with StallF = 0.
- Multi-cycle op: McStartE in cycle 10 and McDoneE in cycle 13 -> StallF/D/E = FlushM = 1 in cycles 10-12, all 0 in cycle 13, and the FSM is in RUN at cycle 14.
- Timeout with MC_TIMEOUT = 4: McStartE and no McDoneE -> McErr pulses at N+5, the stalls release in the same cycle, and the FSM is in RUN at N+6.
- Reset: pull reset_n low mid-BUSY -> all outputs 0 immediately. After release, a fresh McStartE behaves as in the multi-cycle scenario. With HAZARD_PERF_EN defined, the counters read 0 after reset.
